// File: rtl/div_meter_pkg.sv
// Shared constants for the divided-clock ratio meter.
package div_meter_pkg;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_MEASURE   = 2'd2;
endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous divided clock plus rising-edge detect.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clear_n,
  input  logic din,
  output logic s,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
endmodule

// File: rtl/div_ratio_meter.sv
// Measures period and high time of a divided clock in master-clock cycles and
// reports lock once LOCK_N consecutive periods equal the expected ratio.
module div_ratio_meter
  import div_meter_pkg::*;
#(
  parameter int CW          = 8,
  parameter int LOCK_N      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          div_in,
  input  logic          enable,
  input  logic [CW-1:0] expect_period,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          meas_valid,
  output logic          locked,
  output logic          timeout
);
  localparam int            MW      = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic                   s, rise;
  logic [1:0]             state;
  logic [CW-1:0]          per_cnt, hi_cnt;
  logic [MW-1:0]          match_cnt;
  logic [SYNC_STAGES:0]   settle;
  logic                   hit;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .clear_n (clear_n),
    .din     (div_in),
    .s       (s),
    .rise    (rise)
  );

  assign hit = (per_cnt == expect_period) && (expect_period != '0);

  // settle keeps WAIT_LOW from trusting the reset-zeroed synchronizer, so an
  // input already high at release cannot fake a rising edge.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= ST_WAIT_LOW;
      settle     <= '0;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      settle     <= {settle[SYNC_STAGES-1:0], 1'b1};
      meas_valid <= 1'b0;
      if (!enable) begin
        state     <= ST_WAIT_LOW;
        per_cnt   <= '0;
        hi_cnt    <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
        timeout   <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_LOW: if (settle[SYNC_STAGES] && !s) state <= ST_WAIT_RISE;
          ST_WAIT_RISE: if (rise) begin
            per_cnt <= CW'(1);
            hi_cnt  <= CW'(1);
            state   <= ST_MEASURE;
          end
          ST_MEASURE: begin
            if (rise) begin
              period     <= per_cnt;
              high_time  <= hi_cnt;
              meas_valid <= 1'b1;
              timeout    <= 1'b0;
              per_cnt    <= CW'(1);
              hi_cnt     <= CW'(1);
              if (hit) begin
                if (match_cnt != MW'(LOCK_N)) match_cnt <= match_cnt + 1'b1;
                locked <= (int'(match_cnt) + 1 >= LOCK_N);
              end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
              end
            end else if (per_cnt == CNT_MAX) begin
              timeout   <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              state     <= ST_WAIT_LOW;
            end else begin
              per_cnt <= per_cnt + 1'b1;
              if (s && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
            end
          end
          default: state <= ST_WAIT_LOW;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_div_ratio_meter.sv
// Directed bench for div_ratio_meter: expected strobes queued by stimulus, popped by a monitor.
module tb_div_ratio_meter;
  localparam int CW = 8, LOCK_N = 4, SS = 2;

  logic          clk = 1'b0, clear_n = 1'b0, div_in = 1'b0, enable = 1'b1;
  logic [CW-1:0] expect_period = 8'd3;
  logic [CW-1:0] period, high_time;
  logic          meas_valid, locked, timeout;

  typedef struct {
    int per;
    int hi;
    int lk;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int n_tests = 0, n_fail = 0;

  div_ratio_meter #(.CW(CW), .LOCK_N(LOCK_N), .SYNC_STAGES(SS)) dut (
    .clk           (clk),
    .clear_n       (clear_n),
    .div_in        (div_in),
    .enable        (enable),
    .expect_period (expect_period),
    .period        (period),
    .high_time     (high_time),
    .meas_valid    (meas_valid),
    .locked        (locked),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic push(input int p, input int h, input int lk);
    exp_t e;
    e.per = p; e.hi = h; e.lk = lk;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n full periods of p cycles, each starting with h high cycles
  task automatic wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < p; c++) begin
        div_in = (c < h);
        tick();
      end
  endtask

  always @(negedge clk) begin
    if (clear_n && meas_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: period=%0d high=%0d, want no strobe", period, high_time);
      end else begin
        mon_e = q.pop_front();
        check("period", int'(period), mon_e.per);
        check("high_time", int'(high_time), mon_e.hi);
        check("locked_at_strobe", int'(locked), mon_e.lk);
        check("timeout_at_strobe", int'(timeout), 0);
      end
    end
  end

  initial begin
    #2;
    check("rst_period", int'(period), 0);
    check("rst_high_time", int'(high_time), 0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_timeout", int'(timeout), 0);
    tick();
    clear_n = 1'b1;
    repeat (8) tick();

    // divide-by-3 waveform: lock on the 4th strobe
    push(3, 1, 0); push(3, 1, 0); push(3, 1, 0); push(3, 1, 1); push(3, 1, 1);
    wave(3, 1, 6);
    // switch to period 4: first period-4 strobe drops lock
    push(3, 1, 1); push(4, 2, 0); push(4, 2, 0);
    wave(4, 2, 3);
    // period 5 against expect 6: never locks
    expect_period = 8'd6;
    push(4, 2, 0); push(5, 2, 0); push(5, 2, 0); push(5, 2, 0);
    wave(5, 2, 4);
    // relock on period 3
    expect_period = 8'd3;
    push(5, 2, 0); push(3, 1, 0); push(3, 1, 0); push(3, 1, 0); push(3, 1, 1); push(3, 1, 1);
    wave(3, 1, 6);

    // input stuck low: timeout after 255 counted cycles
    div_in = 1'b0;
    repeat (230) tick();
    check("pre_timeout_flag", int'(timeout), 0);
    check("pre_timeout_locked", int'(locked), 1);
    repeat (40) tick();
    check("timeout_flag", int'(timeout), 1);
    check("timeout_locked", int'(locked), 0);

    // restore period 3: first strobe clears timeout, lock rebuilt from zero
    push(3, 1, 0); push(3, 1, 0); push(3, 1, 0); push(3, 1, 1); push(3, 1, 1);
    wave(3, 1, 6);
    check("timeout_cleared", int'(timeout), 0);
    check("relocked", int'(locked), 1);

    // enable drop mid-period
    tick();
    enable = 1'b0;
    repeat (2) tick();
    check("en_period_hold", int'(period), 3);
    check("en_high_hold", int'(high_time), 1);
    check("en_locked", int'(locked), 0);
    check("en_timeout", int'(timeout), 0);
    check("en_meas_valid", int'(meas_valid), 0);
    enable = 1'b1;
    repeat (3) tick();

    // asynchronous clear mid-cycle
    #3;
    clear_n = 1'b0;
    #1;
    check("clr_period", int'(period), 0);
    check("clr_high_time", int'(high_time), 0);
    check("clr_locked", int'(locked), 0);
    check("clr_meas_valid", int'(meas_valid), 0);

    // div_in high across release must not produce a false first edge
    div_in = 1'b1;
    tick();
    tick();
    clear_n = 1'b1;
    repeat (10) tick();
    div_in = 1'b0;
    repeat (3) tick();
    push(5, 2, 0); push(5, 2, 0); push(5, 2, 0);
    wave(5, 2, 3);
    wave(3, 1, 1);
    repeat (10) tick();

    check("sb_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_ratio_meter.md
# div_ratio_meter

Measures the divide ratio and high time of a divided clock signal, such as the output of the MOD-3, MOD-5 and MOD-6 ripple dividers, in units of the master clock `clk`. Each full period of `div_in` produces one period/high-time measurement. `locked` asserts after a run of consecutive periods that equal the expected ratio. The block sits at the consumer end of the divider chain as its self-check and monitor.

## Interface
- `CW`, default 8: width of the period and high-time counters and outputs.
- `LOCK_N`, default 4: number of consecutive matching periods required before `locked` asserts.
- `SYNC_STAGES`, default 2: depth of the synchronizer on `div_in`. Minimum 2.

Ports:
- `clk` in 1: master clock; the same clock the dividers divide.
- `clear_n` in 1: asynchronous, active-low reset.
- `div_in` in 1: divided clock under test. Treated as asynchronous because ripple outputs are skewed and can glitch.
- `enable` in 1: measurement enable. Low means synchronous return to WAIT_LOW.
- `expect_period` in CW: expected period in `clk` cycles. A value of 0 never matches.
- `period` out CW: last measured period in `clk` cycles.
- `high_time` out CW: number of cycles the synchronized `div_in` was high within that period.
- `meas_valid` out 1: single-cycle strobe when `period` and `high_time` update.
- `locked` out 1: asserted after LOCK_N consecutive matches.
- `timeout` out 1: sticky flag meaning no rising edge arrived within 2^CW−1 cycles.

## Operation
- `s` is `div_in` after SYNC_STAGES flops. `s_d` is `s` delayed by one cycle. `rise = s & ~s_d`.
- The FSM has three states: WAIT_LOW, WAIT_RISE, MEASURE.
  - WAIT_LOW: when `s==0`, go to WAIT_RISE. This blocks a false first edge when `div_in` is already high at reset release.
  - WAIT_RISE: on `rise`, set `per_cnt<=1` and `hi_cnt<=1`, then go to MEASURE. No measurement is published.
  - MEASURE, every cycle without `rise`:
    - `per_cnt` increments, saturating at 2^CW−1.
    - `hi_cnt` increments when `s==1`.
  - MEASURE, cycle with `rise`:
    - `period<=per_cnt`, `high_time<=hi_cnt`, `meas_valid<=1`.
    - `per_cnt<=1`, `hi_cnt<=1`.
- Timeout: if `per_cnt` reaches 2^CW−1 in MEASURE without a `rise`:
  - set `timeout<=1`, clear `locked` and `match_cnt`, go to WAIT_LOW;
  - `timeout` stays set until the next published measurement.
- Lock, evaluated at each published measurement:
  - if `per_cnt==expect_period` and `expect_period!=0`, `match_cnt` increments, saturating at LOCK_N, and `locked<=(match_cnt+1>=LOCK_N)`;
  - otherwise `match_cnt<=0` and `locked<=0`.
- `enable` low: go to WAIT_LOW and clear `per_cnt`, `hi_cnt`, `match_cnt`, `locked`, `timeout` and `meas_valid`. `period` and `high_time` hold their last values.
- A change of `expect_period` takes effect at the next published measurement and is not retroactive.
- Reset values: all outputs 0, synchronizer flops 0, state WAIT_LOW.

## Timing
- Latency: a `div_in` rise first sampled at `clk` edge k shows `meas_valid` high after edge k+SYNC_STAGES, for exactly one cycle.
- A clean periodic input of period P produces `period==P` on every measurement after the first full period.
- Detection latency: the first `meas_valid` after entering WAIT_RISE comes one full period after the first rise.
- Minimum measurable period is 2 (toggle every cycle). Shorter pulses are lost by the synchronizer, by design.
- `clear_n` assertion mid-measurement clears everything immediately. Release is followed by the WAIT_LOW → WAIT_RISE → one full period sequence.

## Structure
- Shared package `div_meter_pkg` holds:
  - the state encoding constants `ST_WAIT_LOW=2'd0`, `ST_WAIT_RISE=2'd1`, `ST_MEASURE=2'd2`;
  - nothing else.
- One sub-module, `sync_edge_detect`: SYNC_STAGES synchronizer plus the `s_d` flop. It outputs `s` and `rise`.
- The FSM, counters and lock logic live in the top module.

## Test plan
- MOD-3 waveform (period 3, high 1), `expect_period=3`, LOCK_N=4:
  - every `meas_valid` shows `period=3`, `high_time=1`;
  - `locked` rises with the 4th `meas_valid`.
- Period-5 waveform, high 2 cycles: `period=5`, `high_time=2`; with `expect_period=6`, `locked` stays 0.
- Locked on period 3, then the waveform switches to period 4: the first `period=4` strobe drops `locked` the same cycle and `match_cnt` returns to 0.
- `div_in` held low after lock, CW=8:
  - `timeout=1` and `locked=0` after the 255-cycle count expires;
  - restoring period 3 clears `timeout` at the first new measurement.
- `div_in` high during and after `clear_n` release: no `meas_valid` until a genuine low→high→low→high sequence; the first value is correct.
- `clear_n` pulsed low mid-period, and separately `enable` dropped mid-period:
  - `clear_n` pulse: all outputs go to 0 immediately;
  - `enable` drop: `period` holds its value while `locked`, `timeout` and `meas_valid` go to 0.
